// File: rtl/alarm_pattern_driver_if.sv
// Control/pin bundle between the alarm control FSM (master) and the
// pattern driver (slave).
interface alarm_pattern_driver_if;
  logic       start;
  logic       stop;
  logic [3:0] beeps;
  logic       busy;
  logic       done;
  logic       buzzer;
  logic       lamp;

  modport master (output start, stop, beeps, input busy, done, buzzer, lamp);
  modport slave  (input start, stop, beeps, output busy, done, buzzer, lamp);
endinterface

// File: rtl/alarm_pattern_driver.sv
// Drives buzzer tone and hazard lamp in timed ON/OFF bursts, either for a
// latched number of beeps or continuously until stopped.
module alarm_pattern_driver #(
  parameter int ON_CYCLES  = 1000000,
  parameter int OFF_CYCLES = 1000000,
  parameter int TONE_HALF  = 25000,
  parameter int CNT_W      = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  alarm_pattern_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  // Counters run down to zero, so loads are length-1.
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_HALF - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] tone_q, tone_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             cont_q, cont_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             buzzer_q, buzzer_d;
  logic             lamp_q, lamp_d;
  logic             enter_on;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tone_d      = tone_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    buzzer_d    = 1'b0;
    lamp_d      = 1'b0;
    enter_on    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          remaining_d = bus.beeps;
          cont_d      = (bus.beeps == 4'd0);
          enter_on    = 1'b1;
        end
      end
      ON: begin
        if (bus.stop) begin
          state_d = IDLE;
          phase_d = '0;
          done_d  = 1'b1;
        end else if (phase_q == '0) begin
          state_d = OFF;
          phase_d = OFF_LOAD;
          busy_d  = 1'b1;
        end else begin
          phase_d = phase_q - CNT_W'(1);
          busy_d  = 1'b1;
          lamp_d  = 1'b1;
          if (tone_q == '0) begin
            buzzer_d = ~buzzer_q;
            tone_d   = TONE_LOAD;
          end else begin
            buzzer_d = buzzer_q;
            tone_d   = tone_q - CNT_W'(1);
          end
        end
      end
      OFF: begin
        if (bus.stop) begin
          state_d = IDLE;
          phase_d = '0;
          done_d  = 1'b1;
        end else if (phase_q == '0) begin
          if (!cont_q && remaining_q == 4'd1) begin
            state_d     = IDLE;
            remaining_d = 4'd0;
            done_d      = 1'b1;
          end else begin
            if (!cont_q) remaining_d = remaining_q - 4'd1;
            enter_on = 1'b1;
          end
        end else begin
          phase_d = phase_q - CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Tone restarts high on every ON entry so each burst sounds the same.
    if (enter_on) begin
      state_d  = ON;
      phase_d  = ON_LOAD;
      tone_d   = TONE_LOAD;
      busy_d   = 1'b1;
      lamp_d   = 1'b1;
      buzzer_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      tone_q      <= '0;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      buzzer_q    <= 1'b0;
      lamp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tone_q      <= tone_d;
      remaining_q <= remaining_d;
      cont_q      <= cont_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      buzzer_q    <= buzzer_d;
      lamp_q      <= lamp_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.buzzer = buzzer_q;
  assign bus.lamp   = lamp_q;

endmodule

// File: tb/tb_alarm_pattern_driver.sv
// Scoreboard bench: each scenario queues the expected {busy,done,lamp,buzzer}
// per cycle from the timing rules, then pops and compares as cycles elapse.
module tb_alarm_pattern_driver;
  localparam int ONC = 4;
  localparam int OFC = 3;
  localparam int TH  = 2;
  localparam int P   = ONC + OFC;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e, got;

  alarm_pattern_driver_if bus();

  alarm_pattern_driver #(
    .ON_CYCLES(ONC), .OFF_CYCLES(OFC), .TONE_HALF(TH), .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Expected outputs k cycles after a start accepted with n beeps (0 = continuous).
  function automatic logic [3:0] exp_seq(int k, int n);
    logic [3:0] r;
    int p;
    r = 4'b0000;
    if (k >= 1 && (n == 0 || k <= n * P)) begin
      p    = (k - 1) % P;
      r[3] = 1'b1;
      r[1] = (p < ONC);
      r[0] = (p < ONC) && (((p / TH) % 2) == 0);
    end else if (n != 0 && k == n * P + 1) begin
      r[2] = 1'b1;
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.stop = 1'b0; bus.beeps = 4'd3;
    for (int k = 1; k <= 4; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 3) begin reset = 1'b0; bus.start = 1'b0; end
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL reset k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_two_beeps();
    bus.start = 1'b1; bus.beeps = 4'd2;
    for (int k = 1; k <= 17; k++) exp_q.push_back(exp_seq(k, 2));
    for (int k = 1; k <= 17; k++) begin
      @(posedge clock); #1;
      if (k == 1) bus.start = 1'b0;
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL two_beeps k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_continuous_stop();
    bus.start = 1'b1; bus.beeps = 4'd0;
    for (int k = 1; k <= 20; k++) exp_q.push_back(exp_seq(k, 0));
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.stop  = (k == 20);
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL cont_stop k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_stop_in_on();
    bus.start = 1'b1; bus.beeps = 4'd3;
    exp_q.push_back(exp_seq(1, 3));
    exp_q.push_back(exp_seq(2, 3));
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.stop  = (k == 2);
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL stop_on k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_start_during_busy();
    bus.start = 1'b1; bus.beeps = 4'd1;
    for (int k = 1; k <= 10; k++) exp_q.push_back(exp_seq(k, 1));
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      bus.start = (k == 2);
      if (k == 2) bus.beeps = 4'd5;
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL start_busy k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_start_stop_idle();
    bus.start = 1'b1; bus.stop = 1'b1; bus.beeps = 4'd2;
    for (int k = 1; k <= 3; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      if (k == 2) begin bus.start = 1'b0; bus.stop = 1'b0; end
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL start_stop_idle k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.beeps = 4'd2;
    for (int k = 1; k <= 5; k++) exp_q.push_back(exp_seq(k, 2));
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    for (int k = 8; k <= 16; k++) exp_q.push_back(exp_seq(k - 7, 1));
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      reset     = (k == 5);
      bus.start = (k == 7);
      if (k == 7) bus.beeps = 4'd1;
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL reset_mid k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1; bus.beeps = 4'd1;
    for (int k = 1; k <= 8; k++) exp_q.push_back(exp_seq(k, 1));
    for (int k = 9; k <= 17; k++) exp_q.push_back(exp_seq(k - 8, 1));
    for (int k = 1; k <= 17; k++) begin
      @(posedge clock); #1;
      bus.start = (k == 8);
      e = exp_q.pop_front(); got = {bus.busy, bus.done, bus.lamp, bus.buzzer};
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.beeps = 4'd0; reset = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_two_beeps();
    test_continuous_stop();
    test_stop_in_on();
    test_start_during_busy();
    test_start_stop_idle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
